mem_bus_master: RTL and testbench

Bus initiator for the memory-mapped address space served by the program/data address decoders and the SRAM chip-enable logic. It accepts read or write burst commands, drives the 16-bit address, the read/write strobes and the write data onto the shared bus, and waits for the target's acknowledge. It returns one response per beat and aborts the burst if an acknowledge timeout occurs. It sits between the control/voice front-end and the address-decoded SRAM, Flash and I/O ports.

---
 rtl/mem_bus_master_if.sv | 46 ++++
 rtl/mem_bus_master.sv | 127 ++++++++++++
 tb/tb_mem_bus_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// Command, write-data, response and shared-bus signals of the memory bus initiator.
// The master modport is the initiator's view; slave is the view of whoever drives it.
interface mem_bus_master_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [3:0]    cmd_len;

   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;

   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          rsp_last;

   logic [AW-1:0] bus_addr;
   logic          bus_rd;
   logic          bus_wr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;
   logic          bus_ack;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_valid, wr_data,
      input  bus_rdata, bus_ack,
      output cmd_ready, wr_ready,
      output rsp_valid, rsp_data, rsp_err, rsp_last,
      output bus_addr, bus_rd, bus_wr, bus_wdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_valid, wr_data,
      output bus_rdata, bus_ack,
      input  cmd_ready, wr_ready,
      input  rsp_valid, rsp_data, rsp_err, rsp_last,
      input  bus_addr, bus_rd, bus_wr, bus_wdata
   );
endinterface

// File: rtl/mem_bus_master.sv
// Burst bus initiator: one SETUP/STROBE/RESP pass per beat, strobe bounded by TIMEOUT.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | address driven, strobes low; writes wait here for wr_valid
// STROBE | bus_rd or bus_wr high, counting cycles until ack or timeout
// RESP   | one-cycle response pulse, then next beat or back to IDLE
module mem_bus_master #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   mem_bus_master_if.master  mbus,
   output logic              busy
);
   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TC_MAX  = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

   state_t        state, state_nxt;
   logic          write_q;
   logic [3:0]    len_q;
   logic [3:0]    beat_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;
   logic [TW-1:0] tcnt;
   logic          final_beat;
   logic          timeout_hit;

   assign final_beat  = (beat_q == len_q);
   // tcnt counts completed strobe cycles, so TC_LAST marks the TIMEOUT-th one
   assign timeout_hit = (tcnt == TC_LAST);

   always_comb begin
      state_nxt      = state;
      mbus.cmd_ready = 1'b0;
      mbus.wr_ready  = 1'b0;
      mbus.bus_rd    = 1'b0;
      mbus.bus_wr    = 1'b0;
      mbus.rsp_valid = 1'b0;
      mbus.rsp_err   = 1'b0;
      mbus.rsp_last  = 1'b0;
      mbus.rsp_data  = '0;
      mbus.bus_addr  = addr_q;
      mbus.bus_wdata = wdata_q;
      busy           = (state != IDLE);
      case (state)
         IDLE: begin
            mbus.cmd_ready = 1'b1;
            if (mbus.cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            mbus.wr_ready = write_q;
            if (!write_q || mbus.wr_valid) state_nxt = STROBE;
         end
         STROBE: begin
            mbus.bus_rd = !write_q;
            mbus.bus_wr = write_q;
            if (mbus.bus_ack || timeout_hit) state_nxt = RESP;
         end
         RESP: begin
            mbus.rsp_valid = 1'b1;
            mbus.rsp_err   = err_q;
            mbus.rsp_last  = final_beat || err_q;
            mbus.rsp_data  = rdata_q;
            state_nxt      = (final_beat || err_q) ? IDLE : SETUP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         write_q <= 1'b0;
         len_q   <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tcnt    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (mbus.cmd_valid) begin
                  write_q <= mbus.cmd_write;
                  addr_q  <= mbus.cmd_addr;
                  len_q   <= mbus.cmd_len;
                  beat_q  <= '0;
                  err_q   <= 1'b0;
                  rdata_q <= '0;
                  tcnt    <= '0;
               end
            end
            SETUP: begin
               tcnt <= '0;
               if (write_q && mbus.wr_valid) wdata_q <= mbus.wr_data;
            end
            STROBE: begin
               if (tcnt != TC_MAX) tcnt <= tcnt + 1'b1;
               if (mbus.bus_ack) begin
                  rdata_q <= write_q ? '0 : mbus.bus_rdata;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            RESP: begin
               if (!(final_beat || err_q)) begin
                  addr_q <= addr_q + 1'b1;
                  beat_q <= beat_q + 1'b1;
                  tcnt   <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_master.sv
// Randomised scoreboard bench for mem_bus_master with a behavioural bus target.
module tb_mem_bus_master;
   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int TO    = 15;
   localparam int NOACK = 99;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   mem_bus_master_if #(.AW(AW), .DW(DW)) mbus ();

   mem_bus_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .mbus  (mbus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] data; logic err; logic last; } rsp_t;
   typedef struct { logic [15:0] addr; logic wr; logic [7:0] wdata; } beat_t;

   int n_cmp = 0;
   int n_bad = 0;
   rsp_t  rsp_q[$];
   beat_t bus_q[$];
   int    dly_q[$];
   logic [7:0] model_mem [65536];
   logic [7:0] tgt_mem   [65536];
   int         cur_dly   [16];
   int         cur_stall [16];
   logic [7:0] cur_wd    [16];
   int plan_beats;
   int accepts = 0;
   int strobe_starts = 0;
   logic last_pending = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void clear_cur();
      for (int i = 0; i < 16; i++) begin
         cur_dly[i] = 0; cur_stall[i] = 0; cur_wd[i] = 8'h00;
      end
   endfunction

   // Reference: beats walk the address space modulo 2^16, a missing ack ends the command.
   function automatic void plan(logic w, logic [15:0] a, int len);
      logic [15:0] ai;
      beat_t b;
      rsp_t  r;
      plan_beats = 0;
      for (int i = 0; i <= len; i++) begin
         ai = a + 16'(i);
         b.addr = ai; b.wr = w; b.wdata = cur_wd[i];
         bus_q.push_back(b);
         dly_q.push_back(cur_dly[i]);
         plan_beats++;
         if (cur_dly[i] >= TO) begin
            r = '{data: 8'h00, err: 1'b1, last: 1'b1};
            rsp_q.push_back(r);
            break;
         end
         r.data = w ? 8'h00 : model_mem[ai];
         r.err  = 1'b0;
         r.last = (i == len);
         if (w) model_mem[ai] = cur_wd[i];
         rsp_q.push_back(r);
      end
   endfunction

   task automatic issue_cmd(input logic w, input logic [15:0] a, input int len);
      int k;
      mbus.cmd_write = w;
      mbus.cmd_addr  = a;
      mbus.cmd_len   = 4'(len);
      mbus.cmd_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!mbus.cmd_ready && k < 50);
      chk("cmd_accept", mbus.cmd_ready, 1);
      @(posedge clk); #1;
      mbus.cmd_valid = 1'b0;
   endtask

   task automatic feed_wdata();
      int k;
      for (int i = 0; i < plan_beats; i++) begin
         repeat (cur_stall[i]) begin
            @(negedge clk);
            if (i == 0) begin
               chk("stall_wr_ready", mbus.wr_ready, 1);
               chk("stall_bus_wr", mbus.bus_wr, 0);
            end
            @(posedge clk); #1;
         end
         mbus.wr_data  = cur_wd[i];
         mbus.wr_valid = 1'b1;
         k = 0;
         do begin @(negedge clk); k++; end while (!mbus.wr_ready && k < 100);
         chk("wr_handshake", mbus.wr_ready, 1);
         @(posedge clk); #1;
         mbus.wr_valid = 1'b0;
         mbus.wr_data  = 8'($urandom);
         @(negedge clk);
         chk("strobe_after_wr", mbus.bus_wr, 1);
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while ((rsp_q.size() != 0 || busy) && k < 600);
      chk("cmd_done", (rsp_q.size() == 0 && !busy), 1);
      chk("bus_beats_left", bus_q.size(), 0);
      rsp_q.delete(); bus_q.delete(); dly_q.delete();
      @(posedge clk); #1;
   endtask

   // Response monitor
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (last_pending) begin
            if (!reset) chk("idle_after_last", mbus.cmd_ready, 1);
            last_pending = 1'b0;
         end
         if (mbus.bus_rd || mbus.bus_wr) chk("strobe_exclusive", mbus.bus_rd & mbus.bus_wr, 0);
         if (mbus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_rsp: got rsp_valid with data 0x%0h, want none at %0t",
                        mbus.rsp_data, $time);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_data", mbus.rsp_data, r.data);
               chk("rsp_err", mbus.rsp_err, r.err);
               chk("rsp_last", mbus.rsp_last, r.last);
               if (mbus.rsp_last) last_pending = 1'b1;
            end
         end
      end
   end

   always @(negedge clk)
      if (!reset && mbus.cmd_valid && mbus.cmd_ready) accepts++;

   // Bus target: acks after the planned delay, random ack/rdata noise elsewhere
   initial begin
      int    cnt;
      int    cur_d;
      beat_t eb;
      cnt = 0; cur_d = 0;
      mbus.bus_ack = 1'b0; mbus.bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            cnt = 0; mbus.bus_ack = 1'b0;
            continue;
         end
         if (mbus.bus_rd || mbus.bus_wr) begin
            if (cnt == 0) begin
               strobe_starts++;
               if (bus_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_strobe: got strobe at addr 0x%0h, want none at %0t",
                           mbus.bus_addr, $time);
                  cur_d = NOACK;
               end else begin
                  eb    = bus_q.pop_front();
                  cur_d = dly_q.pop_front();
                  chk("bus_addr", mbus.bus_addr, eb.addr);
                  chk("bus_dir_wr", mbus.bus_wr, eb.wr);
                  if (eb.wr) chk("bus_wdata", mbus.bus_wdata, eb.wdata);
               end
            end
            cnt++;
            if (cur_d < TO && cnt == cur_d + 1) begin
               mbus.bus_ack = 1'b1;
               if (mbus.bus_rd) mbus.bus_rdata = tgt_mem[mbus.bus_addr];
               else begin
                  tgt_mem[mbus.bus_addr] = mbus.bus_wdata;
                  mbus.bus_rdata = 8'($urandom);
               end
            end else begin
               mbus.bus_ack   = 1'b0;
               mbus.bus_rdata = 8'($urandom);
            end
         end else begin
            if (cnt > 0) chk("strobe_len", cnt, (cur_d < TO) ? cur_d + 1 : TO);
            cnt = 0;
            mbus.bus_ack   = ($urandom_range(0, 3) == 0);
            mbus.bus_rdata = 8'($urandom);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic       w;
      logic [15:0] a;
      int         len, k, r, a0, base;

      reset = 1'b1;
      mbus.cmd_valid = 1'b1; mbus.cmd_write = 1'b1; mbus.cmd_addr = 16'h1234; mbus.cmd_len = 4'h3;
      mbus.wr_valid = 1'b1; mbus.wr_data = 8'hA5;
      for (int i = 0; i < 65536; i++) begin
         model_mem[i] = 8'($urandom);
         tgt_mem[i]   = model_mem[i];
      end
      clear_cur();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", mbus.cmd_ready, 1);
      chk("rst_wr_ready", mbus.wr_ready, 0);
      chk("rst_rsp_valid", mbus.rsp_valid, 0);
      chk("rst_rsp_err", mbus.rsp_err, 0);
      chk("rst_rsp_last", mbus.rsp_last, 0);
      chk("rst_rsp_data", mbus.rsp_data, 0);
      chk("rst_bus_rd", mbus.bus_rd, 0);
      chk("rst_bus_wr", mbus.bus_wr, 0);
      chk("rst_bus_addr", mbus.bus_addr, 0);
      chk("rst_bus_wdata", mbus.bus_wdata, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      mbus.cmd_valid = 1'b0; mbus.wr_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // single read, cycle-exact
      model_mem[16'h0010] = 8'h5A; tgt_mem[16'h0010] = 8'h5A;
      clear_cur();
      plan(1'b0, 16'h0010, 0);
      issue_cmd(1'b0, 16'h0010, 0);
      @(negedge clk);
      chk("rd1_c1_addr", mbus.bus_addr, 16'h0010);
      chk("rd1_c1_rd", mbus.bus_rd, 0);
      @(negedge clk);
      chk("rd1_c2_addr", mbus.bus_addr, 16'h0010);
      chk("rd1_c2_rd", mbus.bus_rd, 1);
      @(negedge clk);
      chk("rd1_c3_addr", mbus.bus_addr, 16'h0010);
      chk("rd1_c3_rd", mbus.bus_rd, 0);
      chk("rd1_c3_valid", mbus.rsp_valid, 1);
      chk("rd1_c3_data", mbus.rsp_data, 8'h5A);
      chk("rd1_c3_last", mbus.rsp_last, 1);
      chk("rd1_c3_err", mbus.rsp_err, 0);
      @(negedge clk);
      chk("rd1_c4_ready", mbus.cmd_ready, 1);
      wait_done();

      // write burst wrapping through 0xFFFF, then read it back
      clear_cur();
      cur_wd[0] = 8'h11; cur_wd[1] = 8'h22; cur_wd[2] = 8'h33; cur_wd[3] = 8'h44;
      plan(1'b1, 16'hFFFE, 3);
      issue_cmd(1'b1, 16'hFFFE, 3);
      feed_wdata();
      wait_done();
      clear_cur();
      plan(1'b0, 16'hFFFE, 3);
      issue_cmd(1'b0, 16'hFFFE, 3);
      wait_done();

      // timeout on beat 0 of a 3-beat read
      clear_cur();
      cur_dly[0] = NOACK;
      plan(1'b0, 16'h0400, 2);
      issue_cmd(1'b0, 16'h0400, 2);
      wait_done();

      // write data stalled 5 cycles
      clear_cur();
      cur_stall[0] = 5; cur_wd[0] = 8'hC3;
      plan(1'b1, 16'h0100, 0);
      issue_cmd(1'b1, 16'h0100, 0);
      feed_wdata();
      wait_done();

      // late ack with cmd_valid held high across two commands
      clear_cur();
      cur_dly[0] = TO - 1;
      plan(1'b0, 16'h1234, 0);
      clear_cur();
      plan(1'b0, 16'h2000, 1);
      a0 = accepts;
      mbus.cmd_write = 1'b0; mbus.cmd_addr = 16'h1234; mbus.cmd_len = 4'h0;
      mbus.cmd_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      mbus.cmd_addr = 16'h2000; mbus.cmd_len = 4'h1;
      k = 0;
      do begin @(negedge clk); k++; end while (!mbus.cmd_ready && k < 100);
      chk("held_second_accept", mbus.cmd_ready, 1);
      @(posedge clk); #1;
      mbus.cmd_valid = 1'b0;
      wait_done();
      chk("held_accept_count", accepts - a0, 2);

      // reset during beat 1 strobe of a 4-beat read
      clear_cur();
      cur_dly[1] = 8;
      base = strobe_starts;
      plan(1'b0, 16'h3000, 3);
      issue_cmd(1'b0, 16'h3000, 3);
      k = 0;
      do begin @(negedge clk); k++; end while (strobe_starts < base + 2 && k < 100);
      chk("mid_reach_beat1", strobe_starts - base, 2);
      @(posedge clk); #1;
      reset = 1'b1; mbus.cmd_valid = 1'b1; mbus.wr_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_bus_rd", mbus.bus_rd, 0);
      chk("mid_rsp_valid", mbus.rsp_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_cmd_ready", mbus.cmd_ready, 1);
      rsp_q.delete(); bus_q.delete(); dly_q.delete();
      @(posedge clk); #1;
      mbus.cmd_valid = 1'b0; mbus.wr_valid = 1'b0;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle", busy, 0);
      @(posedge clk); #1;
      clear_cur();
      plan(1'b0, 16'h3001, 1);
      issue_cmd(1'b0, 16'h3001, 1);
      wait_done();

      // randomised commands
      for (int n = 0; n < 50; n++) begin
         clear_cur();
         w   = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 4) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
         len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12)      cur_dly[i] = $urandom_range(0, 3);
            else if (r < 15) cur_dly[i] = TO - 1;
            else if (r < 17) cur_dly[i] = NOACK;
            else             cur_dly[i] = $urandom_range(0, TO - 1);
            cur_stall[i] = $urandom_range(0, 3);
            cur_wd[i]    = 8'($urandom);
         end
         plan(w, a, len);
         issue_cmd(w, a, len);
         if (w) feed_wdata();
         wait_done();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
